// File: rtl/pipe_mem_access_if.sv
// Data-bus port bundle for pipe_mem_access: one outstanding req/ack transaction at a time.
interface pipe_mem_access_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  ack;
  logic [31:0]           rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/pipe_mem_access.sv
// MEM-stage data-memory access unit: one req/ack bus transaction per load/store, with stall.
// Optional MEM_MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and pulse mem_misalign.
module pipe_mem_access #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_wb_en,
  input  logic              mem_mem_re,
  input  logic              mem_mem_we,
  input  logic [2:0]        mem_funct3,
  input  logic [31:0]       mem_alu_res,
  input  logic [31:0]       mem_store_data,
  output logic [31:0]       mem_data_mem_out,
  output logic              mem_stall,
  output logic              mem_bus_err,
  output logic              mem_misalign,
  pipe_mem_access_if.master dbus
);
  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            off_q, off_d;
  logic [2:0]            f3_q, f3_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  drop_q, drop_d;
  logic [31:0]           data_q, data_d;
  logic                  bus_err_q, bus_err_d;
  logic                  misalign_q, misalign_d;
  logic                  accept, trap, finish, dropping;
  logic [31:0]           fmt_wdata;
  logic [3:0]            fmt_wstrb;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = {{24{b[7]}}, b};
      3'b001:  fmt_load = {{16{h[15]}}, h};
      3'b100:  fmt_load = {24'h0, b};
      3'b101:  fmt_load = {16'h0, h};
      default: fmt_load = word;
    endcase
  endfunction

  always_comb begin
    case (mem_funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{mem_store_data[7:0]}};
        fmt_wstrb = 4'b0001 << mem_alu_res[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{mem_store_data[15:0]}};
        fmt_wstrb = mem_alu_res[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        fmt_wdata = mem_store_data;
        fmt_wstrb = 4'b1111;
      end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (mem_funct3[1:0] == 2'b01) ? mem_alu_res[0]
              : (mem_funct3[1:0] != 2'b00) && (mem_alu_res[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  assign accept   = (mem_mem_re | mem_mem_we) & ~flush;
  assign finish   = dbus.ack | (cnt_q == TimeoutLast);
  assign dropping = drop_q | flush;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    off_d      = off_q;
    f3_d       = f3_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    data_d     = data_q;
    bus_err_d  = 1'b0;
    misalign_d = 1'b0;
    mem_stall  = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_stall = accept;
        if (accept) begin
          we_d    = mem_mem_we;
          addr_d  = ADDR_WIDTH'({mem_alu_res[31:2], 2'b00});
          off_d   = mem_alu_res[1:0];
          f3_d    = mem_funct3;
          wdata_d = fmt_wdata;
          wstrb_d = mem_mem_we ? fmt_wstrb : 4'b0000;
          cnt_d   = 8'd0;
          drop_d  = 1'b0;
          if (trap) begin
            state_d    = StDone;
            misalign_d = 1'b1;
            data_d     = 32'h0;
          end else begin
            state_d = StReq;
            req_d   = 1'b1;
          end
        end
      end
      StReq: begin
        mem_stall = 1'b1;
        cnt_d     = cnt_q + 8'd1;
        if (flush) drop_d = 1'b1;
        if (finish) begin
          req_d     = 1'b0;
          bus_err_d = ~dbus.ack;
          // A flushed access still completes on the bus but never reaches DONE.
          state_d   = dropping ? StIdle : StDone;
          if (!dropping) begin
            if (!dbus.ack) data_d = 32'h0;
            else if (!we_q) data_d = fmt_load(f3_q, off_q, dbus.rdata);
          end
        end
      end
      StDone: begin
        if (flush || mem_wb_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      off_q      <= 2'b00;
      f3_q       <= 3'b000;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'b0000;
      cnt_q      <= 8'd0;
      drop_q     <= 1'b0;
      data_q     <= 32'h0;
      bus_err_q  <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      f3_q       <= f3_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      data_q     <= data_d;
      bus_err_q  <= bus_err_d;
      misalign_q <= misalign_d;
    end
  end

  assign dbus.req         = req_q;
  assign dbus.we          = we_q;
  assign dbus.addr        = addr_q;
  assign dbus.wdata       = wdata_q;
  assign dbus.wstrb       = wstrb_q;
  assign mem_data_mem_out = data_q;
  assign mem_bus_err      = bus_err_q;
  assign mem_misalign     = misalign_q;
endmodule
